// File: rtl/gf_pkg.sv
// Shared GF(2^16) definitions for the SDitH datapath: field width, the
// z^2 + z + 0x20 tower constant, the MAC FSM states and a GF(2^8) multiply.
package gf_pkg;

    localparam int GF2P16_W = 16;

    // GF(2^16) = GF(2^8)[z] / (z^2 + z + 0x20)
    localparam logic [7:0] SDITH_IRRED_CST_GF2P16 = 8'h20;

    // Low byte of the GF(2^8) modulus x^8 + x^4 + x^3 + x + 1
    localparam logic [7:0] GF2P8_POLY_LO = 8'h1B;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        FLUSH,
        DONE
    } mac_state_e;

    function automatic logic [7:0] gf256_mul(input logic [7:0] a,
                                             input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = t[7] ? ((t << 1) ^ GF2P8_POLY_LO) : (t << 1);
        end
        return p;
    endfunction

endpackage

// File: rtl/gf_mul_16_s.sv
// Pipelined GF(2^16) multiplier, fixed LAT-cycle latency, no done strobe.
// Ports: i_clk, i_rst_n (async low), i_start (operands valid), i_a, i_b, o_p.
module gf_mul_16_s
    import gf_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [GF2P16_W-1:0] i_a,
    input  logic [GF2P16_W-1:0] i_b,
    output logic [GF2P16_W-1:0] o_p
);

    logic [7:0]          hh;
    logic [7:0]          hl;
    logic [7:0]          lh;
    logic [7:0]          ll;
    logic [GF2P16_W-1:0] prod;
    logic [GF2P16_W-1:0] pipe_d [LAT];
    logic [GF2P16_W-1:0] pipe_q [LAT];

    always_comb begin
        hh = gf256_mul(i_a[15:8], i_b[15:8]);
        hl = gf256_mul(i_a[15:8], i_b[7:0]);
        lh = gf256_mul(i_a[7:0], i_b[15:8]);
        ll = gf256_mul(i_a[7:0], i_b[7:0]);
        // z^2 folds back as z + 0x20
        prod = {hh ^ hl ^ lh,
                ll ^ gf256_mul(hh, SDITH_IRRED_CST_GF2P16)};
        pipe_d[0] = i_start ? prod : '0;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign o_p = pipe_q[LAT-1];

endmodule

// File: rtl/gf_mac_16_s.sv
// Streaming GF(2^16) inner product: acc = XOR of x[k]*y[k], k < i_len.
// Ports: i_clk, i_rst_n, i_start/i_len, i_valid/o_ready, i_x, i_y,
// o_acc/o_done/o_busy; i_acc_init seed only when GF_MAC_INIT_EN is defined.
module gf_mac_16_s
    import gf_pkg::*;
#(
    parameter int LEN_W   = 9,
    parameter int MUL_LAT = 4,
    parameter int REG_OUT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [LEN_W-1:0]    i_len,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [GF2P16_W-1:0] i_x,
    input  logic [GF2P16_W-1:0] i_y,
`ifdef GF_MAC_INIT_EN
    input  logic [GF2P16_W-1:0] i_acc_init,
`endif
    output logic [GF2P16_W-1:0] o_acc,
    output logic                o_done,
    output logic                o_busy
);

    mac_state_e          state_q;
    mac_state_e          state_d;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_d;
    logic [LEN_W-1:0]    issue_q;
    logic [LEN_W-1:0]    issue_d;
    logic [LEN_W-1:0]    retire_q;
    logic [LEN_W-1:0]    retire_d;
    logic [LEN_W-1:0]    ret_next;
    logic [MUL_LAT-1:0]  vld_q;
    logic [MUL_LAT-1:0]  vld_d;
    logic [GF2P16_W-1:0] acc_q;
    logic [GF2P16_W-1:0] acc_d;
    logic [GF2P16_W-1:0] res_q;
    logic [GF2P16_W-1:0] res_d;
    logic [GF2P16_W-1:0] acc_o_q;
    logic                done_o_q;
    logic [GF2P16_W-1:0] mul_p;
    logic [GF2P16_W-1:0] seed;
    logic                start_ok;
    logic                accept;
    logic                retire;

`ifdef GF_MAC_INIT_EN
    assign seed = i_acc_init;
`else
    assign seed = '0;
`endif

    gf_mul_16_s #(
        .LAT (MUL_LAT)
    ) u_mul (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (accept),
        .i_a     (i_x),
        .i_b     (i_y),
        .o_p     (mul_p)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issue_d  = issue_q;
        acc_d    = acc_q;
        res_d    = res_q;
        start_ok = i_start && (state_q == IDLE || state_q == DONE);
        accept   = (state_q == LOAD) && i_valid;
        // tail of the tag line lines up with the product leaving the multiplier
        retire   = vld_q[MUL_LAT-1];
        ret_next = retire_q + LEN_W'(retire);
        retire_d = ret_next;
        vld_d    = vld_q << 1;
        vld_d[0] = accept;
        if (retire) begin
            acc_d = acc_q ^ mul_p;
        end
        if (accept) begin
            issue_d = issue_q + 1'b1;
        end
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_ok) begin
                    len_d    = i_len;
                    issue_d  = '0;
                    retire_d = '0;
                    acc_d    = seed;
                    state_d  = (i_len == '0) ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                if (accept && issue_q == len_q - 1'b1) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // counts the product retiring this cycle
                if (ret_next == len_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                res_d   = acc_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issue_q  <= '0;
            retire_q <= '0;
            vld_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            acc_o_q  <= '0;
            done_o_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issue_q  <= issue_d;
            retire_q <= retire_d;
            vld_q    <= vld_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            acc_o_q  <= res_q;
            done_o_q <= (state_q == DONE);
        end
    end

    assign o_ready = (state_q == LOAD);
    assign o_busy  = (state_q == LOAD) || (state_q == DRAIN) ||
                     (state_q == FLUSH) ||
                     ((REG_OUT != 0) && (state_q == DONE));
    assign o_done  = (REG_OUT != 0) ? done_o_q : (state_q == DONE);
    assign o_acc   = (REG_OUT != 0) ? acc_o_q : res_q;

endmodule
